// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 serial-parallel multiplier.
// Optional build macro: MULT_EARLY_TERM_EN (early completion when the
// remaining multiplier bits are all zero).
package mult_pkg;

    // Default operand width; must be even and >= 4.
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of radix-4 steps for a given operand width.
    function automatic int steps_f(input int w);
        return w / 2;
    endfunction

    // Step counter width for a given operand width (at least one bit).
    function automatic int cnt_w_f(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

    localparam int DEF_STEPS = steps_f(DEF_DATA_WIDTH);
    localparam int DEF_CNT_W = cnt_w_f(DEF_DATA_WIDTH);

endpackage

// File: rtl/mult_r4_step.sv
// One radix-4 shift-add step: selects 0/A/2A/3A by the 2-bit digit, shifts
// it into position 2k and adds it to the running accumulator.
module mult_r4_step
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH+1:0]   a3,
    input  logic [1:0]              d,
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [CNT_W-1:0]        k,
    output logic [2*DATA_WIDTH-1:0] acc_next
);

    logic [DATA_WIDTH+1:0]   pp;
    logic [2*DATA_WIDTH-1:0] pp_ext;
    logic [CNT_W:0]          shamt;

    // Partial product selected by the current multiplier digit.
    always_comb begin
        pp = '0;
        case (d)
            2'd0:    pp = '0;
            2'd1:    pp = {2'b00, a};
            2'd2:    pp = {1'b0, a, 1'b0};
            default: pp = a3;
        endcase
    end

    assign pp_ext   = {{(DATA_WIDTH-2){1'b0}}, pp};
    assign shamt    = {k, 1'b0};
    // The full product fits in 2*DATA_WIDTH bits, so the sum never wraps.
    assign acc_next = acc + (pp_ext << shamt);

endmodule

// File: rtl/serial_parallel_mult.sv
// Unsigned DATA_WIDTH x DATA_WIDTH multiplier, multiplier consumed 2 bits
// per clock. Fixed latency of DATA_WIDTH/2 edges by default.
// Optional build macro: MULT_EARLY_TERM_EN -- finish as soon as the
// unconsumed multiplier bits are all zero (1 .. DATA_WIDTH/2 edges).
//
// Handshake: i_valid is a one-cycle operand strobe, taken only in IDLE or
// DONE (there is no ready; strobes while BUSY are dropped). o_valid is a
// level that rises on the completion edge and stays high, with o_c stable,
// until the edge that accepts the next operands.
module serial_parallel_mult
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic                    i_valid,
    output logic                    o_valid,
    output logic [2*DATA_WIDTH-1:0] o_c,
    output state_t                  dbg_state
);

    localparam int STEP_CNT = steps_f(DATA_WIDTH);
    localparam int CW       = cnt_w_f(DATA_WIDTH);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH+1:0]   a3_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [CW-1:0]           cnt_q;

    logic [1:0]              digit;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic                    last_step;

    assign digit = b_q[{cnt_q, 1'b0} +: 2];

    mult_r4_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CW)
    ) u_step (
        .a        (a_q),
        .a3       (a3_q),
        .d        (digit),
        .acc      (acc_q),
        .k        (cnt_q),
        .acc_next (acc_next)
    );

`ifdef MULT_EARLY_TERM_EN
    logic [CW+1:0] rem_sh;
    logic          rem_zero;

    // Bits above the digit consumed this cycle; if none are set, this step is the last.
    assign rem_sh    = {1'b0, cnt_q, 1'b0} + (CW+2)'(2);
    assign rem_zero  = ((b_q >> rem_sh) == '0);
    assign last_step = (cnt_q == CW'(STEP_CNT-1)) || rem_zero;
`else
    assign last_step = (cnt_q == CW'(STEP_CNT-1));
`endif

    assign dbg_state = state_q;

    // Control FSM plus operand, accumulator, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a3_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_c     <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        a3_q    <= {2'b00, i_a} + {1'b0, i_a, 1'b0};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        o_valid <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        o_c     <= acc_next;
                        o_valid <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parallel_mult.sv
// Directed bench for serial_parallel_mult (DATA_WIDTH = 32). A reference
// model computes a*b and the completion latency from the operands; a
// per-cycle compare checks o_valid, o_c and the FSM state against it, and
// each directed op also checks literal products and latencies.
module tb_serial_parallel_mult;
  import mult_pkg::*;

  localparam int W = 32;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   i_a = '0;
  logic [W-1:0]   i_b = '0;
  logic           i_valid = 1'b0;
  logic           o_valid;
  logic [2*W-1:0] o_c;
  state_t         dbg_state;

  always #5 clk = ~clk;

  serial_parallel_mult #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_valid   (i_valid),
    .o_valid   (o_valid),
    .o_c       (o_c),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges from acceptance to o_valid, derived from the multiplier value.
  function automatic int exp_lat(input logic [W-1:0] b);
    int n;
    if (!EARLY) return W / 2;
    n = 1;
    for (int k = 0; k < W / 2; k++)
      if (b[2*k +: 2] != 2'b00) n = k + 1;
    return n;
  endfunction

  // ---------------- reference model ----------------
  logic           m_busy  = 1'b0;
  logic           m_valid = 1'b0;
  logic [2*W-1:0] m_c     = '0;
  logic [2*W-1:0] m_prod  = '0;
  int             m_left  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_c     <= '0;
      m_left  <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_c     <= m_prod;
      end
    end else if (i_valid) begin
      m_prod  <= 64'(i_a) * 64'(i_b);
      m_left  <= exp_lat(i_b);
      m_busy  <= 1'b1;
      m_valid <= 1'b0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_o_valid", 64'(o_valid), 64'(m_valid));
      check("cyc_o_c", o_c, m_c);
      check("cyc_state", 64'(dbg_state),
            64'(m_busy ? BUSY : (m_valid ? DONE : IDLE)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] exp_c);
    @(posedge clk); #1;
    i_a = a; i_b = b; i_valid = 1'b1;
    exp_q.push_back(exp_c);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_n, input int already);
    int n;
    logic [63:0] exp_c;
    n = already;
    while (!o_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    exp_c = exp_q.pop_front();
    if (!o_valid) check("timeout", 64'(o_valid), 64'd1);
    else begin
      check("latency", 64'(n), 64'(exp_n));
      check("result", o_c, exp_c);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp_c, input int exp_n);
    start_op(a, b, exp_c);
    wait_done(exp_n, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] ra, rb;
    int pulse_at, rst_at;

    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_c", o_c, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    run_op(32'd0, 32'd0, 64'd0, EARLY ? 1 : 16);
    run_op(32'd0, 32'd1, 64'd0, EARLY ? 1 : 16);
    run_op(32'd1, 32'd0, 64'd0, EARLY ? 1 : 16);
    run_op(32'd342, 32'd25, 64'h2166, EARLY ? 3 : 16);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16);
    run_op(32'd342, 32'd3, 64'd1026, EARLY ? 1 : 16);

    // Strobe during BUSY must be ignored.
    pulse_at = EARLY ? 1 : 3;
    start_op(32'd7, 32'd9, 64'd63);
    repeat (pulse_at - 1) @(posedge clk);
    #1;
    i_a = 32'd5; i_b = 32'd5; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_done(EARLY ? 2 : 16, pulse_at);
    repeat (3) @(posedge clk);
    #1;
    check("idle_o_valid", 64'(o_valid), 64'd1);
    check("idle_o_c", o_c, 64'd63);
    run_op(32'd3, 32'd4, 64'd12, EARLY ? 2 : 16);

    // Reset mid-operation aborts without a result.
    rst_at = EARLY ? 1 : 8;
    start_op(32'd342, 32'd25, 64'h2166);
    void'(exp_q.pop_back());
    repeat (rst_at - 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_o_valid", 64'(o_valid), 64'd0);
    check("abort_o_c", o_c, 64'd0);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    // Random pairs, then small multipliers.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom;
      run_op(ra, rb, 64'(ra) * 64'(rb), exp_lat(rb));
    end
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 255);
      run_op(ra, rb, 64'(ra) * 64'(rb), exp_lat(rb));
    end

    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
